// File: rtl/mac_result_requantizer_if.sv
// Result stream between the MAC accumulator and the requantizer FIFO:
// accumulator results come in on in_*, requantized operands leave on out_*.
interface mac_result_requantizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_mag;
    logic        in_sign;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mag;
    logic        out_sign;
    logic        out_sat;

    // Producer of accumulator results and consumer of quantized operands.
    modport master (
        output in_valid, in_mag, in_sign, relu_en, out_ready,
        input  in_ready, out_valid, out_mag, out_sign, out_sat
    );

    // The requantizer itself.
    modport slave (
        input  in_valid, in_mag, in_sign, relu_en, out_ready,
        output in_ready, out_valid, out_mag, out_sign, out_sat
    );
endinterface

// File: rtl/mac_result_requantizer.sv
// Rounds, scales, optionally ReLU-clamps and saturates 33-bit sign-magnitude
// accumulator results to 16-bit sign-magnitude operands, buffered in a FIFO.
module mac_result_requantizer #(
    parameter int FRAC_SHIFT = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_result_requantizer_if.slave bus,
    output logic [CNT_W-1:0]       count,
    output logic [15:0]            sat_total
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [33:0]      RND      = 34'(1) << (FRAC_SHIFT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry layout: {sat, sign, mag[15:0]}
    logic [17:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      sat_total_q, sat_total_d;

    logic        in_ready;
    logic        out_valid;
    logic        push;
    logic        pop;
    logic [33:0] rounded;
    logic [15:0] q_mag;
    logic        q_sign;
    logic        q_sat;
    logic [17:0] head;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // Round half up on the magnitude, so rounding is symmetric about zero.
    assign rounded = ({1'b0, bus.in_mag} + RND) >> FRAC_SHIFT;

    always_comb begin
        q_mag  = rounded[15:0];
        q_sign = bus.in_sign;
        q_sat  = 1'b0;
        if (|rounded[33:16]) begin
            q_mag = 16'hFFFF;
            q_sat = 1'b1;
        end
        // ReLU takes precedence: a clamped result is never flagged saturated.
        if (bus.relu_en && bus.in_sign) begin
            q_mag  = '0;
            q_sign = 1'b0;
            q_sat  = 1'b0;
        end
        if (q_mag == '0) begin
            q_sign = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q;
        sat_total_d = sat_total_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push && q_sat && (sat_total_q != 16'hFFFF)) begin
            sat_total_d = sat_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sat_total_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sat_total_q <= sat_total_d;
        end
    end

    // Storage needs no reset: stale entries are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {q_sat, q_sign, q_mag};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_mag   = out_valid ? head[15:0] : '0;
    assign bus.out_sign  = out_valid ? head[16]   : 1'b0;
    assign bus.out_sat   = out_valid ? head[17]   : 1'b0;
    assign count         = count_q;
    assign sat_total     = sat_total_q;

endmodule

// File: tb/tb_mac_result_requantizer.sv
// Directed plus randomized checks of mac_result_requantizer against a
// queue-based reference model built from the quantization rules.
module tb_mac_result_requantizer;

    localparam int FS    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] count;
    logic [15:0]      sat_total;

    mac_result_requantizer_if bus ();

    mac_result_requantizer #(
        .FRAC_SHIFT(FS),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .count    (count),
        .sat_total(sat_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {sat, sign, mag}, plus saturation counter.
    logic [17:0] model_q[$];
    int          model_sat;

    function automatic logic [17:0] quant(input longint unsigned mag, input bit sgn, input bit relu);
        longint unsigned r;
        logic [15:0] m;
        bit s;
        bit sat;
        r   = (mag + (64'd1 << (FS - 1))) / (64'd1 << FS);
        sat = (r > 65535);
        m   = sat ? 16'hFFFF : 16'(r);
        s   = sgn;
        if (relu && sgn) begin
            m   = 0;
            s   = 0;
            sat = 0;
        end
        if (m == 0) s = 0;
        return {sat, s, m};
    endfunction

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model,
    // then advance the model across the edge.
    task automatic cycle(input bit iv, input logic [32:0] mag, input bit sgn,
                         input bit relu, input bit ordy);
        logic [17:0] hd;
        bit do_push;
        bit do_pop;
        bus.in_valid  = iv;
        bus.in_mag    = mag;
        bus.in_sign   = sgn;
        bus.relu_en   = relu;
        bus.out_ready = ordy;
        #1;
        hd = (model_q.size() != 0) ? model_q[0] : 18'h0;
        check("count",     count,         model_q.size());
        check("in_ready",  bus.in_ready,  model_q.size() != DEPTH);
        check("out_valid", bus.out_valid, model_q.size() != 0);
        check("out_mag",   bus.out_mag,   hd[15:0]);
        check("out_sign",  bus.out_sign,  hd[16]);
        check("out_sat",   bus.out_sat,   hd[17]);
        check("sat_total", sat_total,     model_sat);
        do_push = iv && (model_q.size() != DEPTH);
        do_pop  = ordy && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            hd = quant(mag, sgn, relu);
            model_q.push_back(hd);
            if (hd[17] && model_sat != 16'hFFFF) model_sat++;
        end
        $display("cycle t=%0t push=%0b pop=%0b mag=0x%0h sign=%0b relu=%0b count=%0d",
                 $time, do_push, do_pop, mag, sgn, relu, count);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 33'h0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        logic [32:0] rmag;
        model_sat     = 0;
        bus.in_valid  = 0;
        bus.in_mag    = '0;
        bus.in_sign   = 0;
        bus.relu_en   = 0;
        bus.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_count", count, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_mag", bus.out_mag, 0);
        idle(1'b0);

        // Rounding, sign, ReLU, negative zero, saturation (one entry in flight)
        cycle(1, 33'h180, 0, 0, 1); check("round_up", bus.out_mag, 2);
        cycle(1, 33'h17F, 0, 0, 1); check("round_down", bus.out_mag, 1);
        cycle(1, 33'h300, 1, 0, 1); check("neg_mag", bus.out_mag, 3);
                                    check("neg_sign", bus.out_sign, 1);
        cycle(1, 33'h300, 1, 1, 1); check("relu_mag", bus.out_mag, 0);
                                    check("relu_sign", bus.out_sign, 0);
        cycle(1, 33'h07F, 1, 0, 1); check("negzero_sign", bus.out_sign, 0);
        cycle(1, 33'h1_0000_0000, 1, 0, 1);
        check("sat_mag", bus.out_mag, 16'hFFFF);
        check("sat_flag", bus.out_sat, 1);
        check("sat_total1", sat_total, 1);
        cycle(1, 33'h0FF_FF7F, 0, 0, 1);
        check("edge_mag", bus.out_mag, 16'hFFFF);
        check("edge_sat", bus.out_sat, 0);
        idle(1'b1);

        // Fill to full, refused fifth push, then drain in order
        for (int i = 1; i <= 4; i++) cycle(1, 33'(i) << 8, 0, 0, 0);
        check("full_count", count, 4);
        check("full_ready", bus.in_ready, 0);
        cycle(1, 33'h500, 0, 0, 0);
        check("full_hold", count, 4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", bus.out_mag, i);
            idle(1'b1);
        end
        check("drained", bus.out_valid, 0);

        // Concurrent push/pop at count=2 across pointer wrap
        cycle(1, 33'h100, 0, 0, 0);
        cycle(1, 33'h200, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 33'(10 + i) << 8, 0, 0, 1);
        check("conc_count", count, 2);
        check("conc_head", bus.out_mag, 18);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset between edges with three entries buffered
        for (int i = 0; i < 3; i++) cycle(1, 33'h700, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_sat_total", sat_total, 0);
        model_q.delete();
        model_sat = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1, 33'h200, 0, 0, 0);
        check("post_rst_mag", bus.out_mag, 2);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       rmag = 33'($urandom_range(0, 1023));
                1:       rmag = 33'($urandom_range(16'hFF00, 24'hFFFFFF));
                2:       rmag = {1'($urandom), 32'($urandom)};
                default: rmag = 33'($urandom);
            endcase
            cycle(1'($urandom_range(0, 3) != 0), rmag, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_requantizer.md
Name: mac_result_requantizer

Overview:
- Receiving end of the MAC output interface.
- Consumes the 33-bit sign-magnitude accumulator result (m, sign) produced by the mac block.
- Rounds, scales, optionally ReLU-clamps and saturates it back to the 16-bit sign-magnitude operand format (a/asign style), so results can feed the next layer's MAC operands.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.

Parameters:
- FRAC_SHIFT, 8: right-shift applied to the accumulator magnitude (range 1..16).
- DEPTH, 4: FIFO entries (power of two, 2..16).
- CNT_W, 3: width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MAC result present on in_mag/in_sign.
- in_ready  out  1  block can accept a result this cycle.
- in_mag  in  33  accumulator magnitude (mac m).
- in_sign  in  1  accumulator sign, 1 = negative (mac sign).
- relu_en  in  1  clamp negative results to zero; sampled at accept.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_mag  out  16  quantized magnitude.
- out_sign  out  1  quantized sign.
- out_sat  out  1  head entry was saturated.
- count  out  CNT_W  current FIFO occupancy.
- sat_total  out  16  running count of saturated accepts; sticks at 0xFFFF.

Behaviour:
- Reset (async, rst=1): FIFO pointers = 0, count = 0, sat_total = 0, out_valid = 0, and out_mag/out_sign/out_sat = 0. Reset mid-operation discards all buffered entries; in_ready = 1 the cycle after rst falls.
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on count, never on out_ready. When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (count != 0).
- Quantization is combinational on the accept path, and the result is written into the FIFO at the accepting edge:
  - r = (in_mag + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT, computed in 34 bits (round half up on magnitude, symmetric about zero).
  - If r > 65535: mag = 65535, sat = 1. Otherwise mag = r[15:0], sat = 0.
  - If relu_en & in_sign: mag = 0, sign = 0, sat = 0. ReLU wins over saturation.
  - If the final mag == 0: sign forced to 0 (no negative zero).
- Latency: a result accepted at edge k is visible on out_* after edge k (out_valid=1 in cycle k+1) if the FIFO was empty. There is no combinational in-to-out path.
- Outputs: out_mag/out_sign/out_sat show the FIFO head while out_valid=1, and are 0 when empty.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, head advances, new entry written at the tail.
- Push and pop on an empty FIFO cannot coincide (out_valid=0).
- Pointers wrap modulo DEPTH.
- sat_total increments on each push with sat=1 and saturates at 0xFFFF (no wrap).
- Inputs are ignored when in_ready=0; in_valid may be held high across stalls. Data is taken only on the accepting edge.

Test Plan (FRAC_SHIFT=8, DEPTH=4):
- Rounding: push in_mag=0x180, sign=0 -> out_mag=2, out_sign=0, out_sat=0. Push in_mag=0x17F -> out_mag=1.
- Negative / ReLU: push in_mag=0x300, sign=1, relu_en=0 -> out_mag=3, out_sign=1. Same push with relu_en=1 -> out_mag=0, out_sign=0. Push in_mag=0x7F, sign=1 -> out_mag=0, out_sign=0 (no negative zero).
- Saturation: push in_mag=0x1_0000_0000, sign=1 -> out_mag=0xFFFF, out_sign=1, out_sat=1, sat_total=1. Push in_mag=0x0FF_FF7F -> out_mag=0xFFFF, out_sat=0 (rounding reaches exactly 65535).
- Full / back-pressure: out_ready=0, push values 1..4 (mag<<8) -> count=4, in_ready=0, and a 5th in_valid is not accepted. Then out_ready=1 -> outputs 1,2,3,4 in order on consecutive cycles; in_ready=1 after the first pop.
- Concurrent push/pop: count=2 with push and pop every cycle for 10 cycles -> count stays 2, order preserved across pointer wrap.
- Reset mid-operation: count=3, assert rst asynchronously between edges -> out_valid=0, count=0, sat_total=0 immediately. After release, a push of 0x200 gives out_mag=2.
